// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI slave port among MASTERS requesters.
// One transaction may be outstanding at a time; a missing response turns into an error after TIMEOUT cycles.
module obi_rr_arbiter #(
    parameter int unsigned MASTERS = 3,
    parameter int unsigned TIMEOUT = 16,
    localparam int unsigned IDX_W  = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [MASTERS-1:0]      master_req_i,
    output logic [MASTERS-1:0]      master_gnt_o,
    output logic [MASTERS-1:0]      master_rvalid_o,
    output logic [MASTERS-1:0]      master_err_o,
    input  logic [MASTERS-1:0]      master_we_i,
    input  logic [MASTERS*4-1:0]    master_be_i,
    input  logic [MASTERS*32-1:0]   master_addr_i,
    input  logic [MASTERS*32-1:0]   master_wdata_i,
    output logic [31:0]             master_rdata_o,
    output logic                    slave_req_o,
    input  logic                    slave_gnt_i,
    input  logic                    slave_rvalid_i,
    output logic                    slave_we_o,
    output logic [3:0]              slave_be_o,
    output logic [31:0]             slave_addr_o,
    output logic [31:0]             slave_wdata_o,
    input  logic [31:0]             slave_rdata_i,
    output logic                    busy_o,
    output logic [IDX_W-1:0]        owner_o
);

    typedef enum logic {
        IDLE,
        WAIT_RSP
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] owner;
    logic [7:0]       cnt;

    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] next_ptr;
    logic             win_valid;
    logic             req_act;
    logic             grant_act;
    logic             in_wait;
    logic             timeout_hit;
    logic             rsp_fire;

    // Rotating priority: masters at or above rr_ptr first, then wrap to the ones below it.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        win_valid = 1'b0;
        winner    = '0;
        for (int unsigned j = 0; j < MASTERS; j++) begin
            if (!win_valid && master_req_i[j] && (j >= 32'(rr_ptr))) begin
                win_valid = 1'b1;
                winner    = IDX_W'(j);
            end
        end
        for (int unsigned j = 0; j < MASTERS; j++) begin
            if (!win_valid && master_req_i[j] && (j < 32'(rr_ptr))) begin
                win_valid = 1'b1;
                winner    = IDX_W'(j);
            end
        end
    end

    assign next_ptr    = (32'(winner) == MASTERS - 1) ? '0 : winner + IDX_W'(1);
    assign req_act     = (state == IDLE) && win_valid && !rst_i;
    assign grant_act   = req_act && slave_gnt_i;
    assign in_wait     = (state == WAIT_RSP) && !rst_i;
    assign timeout_hit = (cnt == 8'(TIMEOUT - 1));
    // A real response in the timeout cycle wins over the error.
    assign rsp_fire    = in_wait && (slave_rvalid_i || timeout_hit);

    assign slave_req_o    = req_act;
    assign busy_o         = in_wait;
    assign owner_o        = owner;
    assign master_rdata_o = (rsp_fire && slave_rvalid_i) ? slave_rdata_i : 32'h0;

    always_comb begin
        slave_we_o      = 1'b0;
        slave_be_o      = 4'h0;
        slave_addr_o    = 32'h0;
        slave_wdata_o   = 32'h0;
        master_gnt_o    = '0;
        master_rvalid_o = '0;
        master_err_o    = '0;
        for (int unsigned j = 0; j < MASTERS; j++) begin
            if (req_act && (32'(winner) == j)) begin
                slave_we_o      = master_we_i[j];
                slave_be_o      = master_be_i[4*j +: 4];
                slave_addr_o    = master_addr_i[32*j +: 32];
                slave_wdata_o   = master_wdata_i[32*j +: 32];
                master_gnt_o[j] = slave_gnt_i;
            end
            if (rsp_fire && (32'(owner) == j)) begin
                master_rvalid_o[j] = 1'b1;
                master_err_o[j]    = !slave_rvalid_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (rst_i) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_act) begin
                        owner  <= winner;
                        rr_ptr <= next_ptr;
                        cnt    <= '0;
                        state  <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (cnt != 8'hFF) begin
                        cnt <= cnt + 8'd1;
                    end
                    if (rsp_fire) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Self-checking bench for obi_rr_arbiter: directed scenarios plus random traffic,
// each cycle compared against a transaction-level model of the arbiter.
module tb_obi_rr_arbiter;

    localparam int MASTERS = 3;
    localparam int TIMEOUT = 16;
    localparam int IDX_W   = $clog2(MASTERS);
    localparam int VW      = 3*MASTERS + 32 + 1 + 1 + 4 + 32 + 32 + 1 + IDX_W;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [MASTERS-1:0]    req;
    logic [MASTERS-1:0]    we;
    logic [MASTERS*4-1:0]  be;
    logic [MASTERS*32-1:0] addr;
    logic [MASTERS*32-1:0] wdata;
    logic                  sgnt;
    logic                  srvalid;
    logic [31:0]           srdata;

    logic [MASTERS-1:0]    master_gnt_o;
    logic [MASTERS-1:0]    master_rvalid_o;
    logic [MASTERS-1:0]    master_err_o;
    logic [31:0]           master_rdata_o;
    logic                  slave_req_o;
    logic                  slave_we_o;
    logic [3:0]            slave_be_o;
    logic [31:0]           slave_addr_o;
    logic [31:0]           slave_wdata_o;
    logic                  busy_o;
    logic [IDX_W-1:0]      owner_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Transaction-level model: who owns the slave, how long the response has been pending.
    bit          m_busy  = 1'b0;
    int          m_owner = 0;
    int          m_ptr   = 0;
    int          m_age   = 0;
    int          exp_win = -1;
    logic [VW-1:0] exp_all;

    obi_rr_arbiter #(.MASTERS(MASTERS), .TIMEOUT(TIMEOUT)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .master_req_i   (req),
        .master_gnt_o   (master_gnt_o),
        .master_rvalid_o(master_rvalid_o),
        .master_err_o   (master_err_o),
        .master_we_i    (we),
        .master_be_i    (be),
        .master_addr_i  (addr),
        .master_wdata_i (wdata),
        .master_rdata_o (master_rdata_o),
        .slave_req_o    (slave_req_o),
        .slave_gnt_i    (sgnt),
        .slave_rvalid_i (srvalid),
        .slave_we_o     (slave_we_o),
        .slave_be_o     (slave_be_o),
        .slave_addr_o   (slave_addr_o),
        .slave_wdata_o  (slave_wdata_o),
        .slave_rdata_i  (srdata),
        .busy_o         (busy_o),
        .owner_o        (owner_o)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] obs();
        return {master_gnt_o, master_rvalid_o, master_err_o, master_rdata_o, slave_req_o,
                slave_we_o, slave_be_o, slave_addr_o, slave_wdata_o, busy_o, owner_o};
    endfunction

    task automatic model_eval();
        logic [MASTERS-1:0] g  = '0;
        logic [MASTERS-1:0] rv = '0;
        logic [MASTERS-1:0] er = '0;
        logic [31:0] rd = '0;
        logic [31:0] a  = '0;
        logic [31:0] wd = '0;
        logic [3:0]  e  = '0;
        logic sr = 1'b0;
        logic w  = 1'b0;
        logic b  = 1'b0;
        int   win = -1;
        if (!rst) begin
            if (!m_busy) begin
                for (int k = 0; k < MASTERS; k++)
                    if (win < 0 && req[(m_ptr + k) % MASTERS]) win = (m_ptr + k) % MASTERS;
                if (win >= 0) begin
                    sr = 1'b1;
                    w  = we[win];
                    e  = be[win*4 +: 4];
                    a  = addr[win*32 +: 32];
                    wd = wdata[win*32 +: 32];
                    g[win] = sgnt;
                end
            end else begin
                b = 1'b1;
                if (srvalid) begin
                    rv[m_owner] = 1'b1;
                    rd = srdata;
                end else if (m_age == TIMEOUT) begin
                    rv[m_owner] = 1'b1;
                    er[m_owner] = 1'b1;
                end
            end
        end
        exp_win = win;
        exp_all = {g, rv, er, rd, sr, w, e, a, wd, b, IDX_W'(m_owner)};
    endtask

    task automatic model_advance();
        if (rst) begin
            m_busy = 1'b0; m_ptr = 0; m_owner = 0; m_age = 0;
        end else if (!m_busy) begin
            if (exp_win >= 0 && sgnt) begin
                m_owner = exp_win;
                m_ptr   = (exp_win + 1) % MASTERS;
                m_busy  = 1'b1;
                m_age   = 1;
            end
        end else if (srvalid || m_age == TIMEOUT) begin
            m_busy = 1'b0;
        end else begin
            m_age++;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_advance();
        #1;
        cyc++;
    endtask

    task automatic random_fields();
        for (int i = 0; i < MASTERS; i++) begin
            we[i]            = 1'($urandom);
            be[i*4 +: 4]     = 4'($urandom);
            addr[i*32 +: 32] = $urandom;
            wdata[i*32 +: 32] = $urandom;
        end
        srdata = $urandom;
    endtask

    task automatic drain();
        if (m_busy) begin
            req = '0; srvalid = 1'b1; srdata = $urandom;
            settle();
            n_checks++;
            if (obs() !== exp_all) begin
                n_fail++; $display("FAIL drain cyc=%0d got=%h exp=%h", cyc, obs(), exp_all);
            end
            advance();
        end
        srvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; sgnt = 1'b1;
        advance();
        for (int i = 0; i < 3; i++) begin
            req = 3'($urandom); srvalid = 1'($urandom); random_fields();
            settle();
            n_checks++;
            if (obs() !== exp_all) begin
                n_fail++; $display("FAIL reset_outputs cyc=%0d got=%h exp=%h", cyc, obs(), exp_all);
            end
            n_checks++;
            if (obs() !== '0) begin
                n_fail++; $display("FAIL reset_all_zero cyc=%0d got=%h exp=0", cyc, obs());
            end
            advance();
        end
        rst = 1'b0; srvalid = 1'b0;
    endtask

    task automatic test_rotation();
        int order[$];
        int expected[6] = '{0, 1, 2, 0, 1, 2};
        req = '1; sgnt = 1'b1;
        for (int i = 0; i < 12; i++) begin
            random_fields();
            srvalid = m_busy;
            settle();
            for (int j = 0; j < MASTERS; j++) if (master_gnt_o[j]) order.push_back(j);
            n_checks++;
            if (obs() !== exp_all) begin
                n_fail++; $display("FAIL rotation cyc=%0d got=%h exp=%h", cyc, obs(), exp_all);
            end
            advance();
        end
        n_checks++;
        if (order.size() != 6) begin
            n_fail++; $display("FAIL rotation_count got=%0d exp=6", order.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (order[i] != expected[i]) begin
                    n_fail++; $display("FAIL rotation_order idx=%0d got=%0d exp=%0d", i, order[i], expected[i]);
                end
            end
        end
        drain();
    endtask

    task automatic test_single_write();
        random_fields();
        req = 3'b100; sgnt = 1'b1; srvalid = 1'b0;
        we[2] = 1'b1; be[11:8] = 4'hF; addr[95:64] = 32'h1000_0004; wdata[95:64] = 32'hA5A5_5A5A;
        settle();
        n_checks++;
        if ({slave_req_o, slave_we_o, slave_be_o, slave_addr_o, slave_wdata_o, master_gnt_o} !==
            {1'b1, 1'b1, 4'hF, 32'h1000_0004, 32'hA5A5_5A5A, 3'b100}) begin
            n_fail++;
            $display("FAIL single_write_fwd got req=%b we=%b be=%h addr=%h wdata=%h gnt=%b exp 1 1 f 10000004 a5a55a5a 100",
                     slave_req_o, slave_we_o, slave_be_o, slave_addr_o, slave_wdata_o, master_gnt_o);
        end
        advance();
        req = '0; srvalid = 1'b1; srdata = $urandom;
        settle();
        n_checks++;
        if ({master_rvalid_o, master_err_o, master_rdata_o, owner_o} !== {3'b100, 3'b000, srdata, 2'd2}) begin
            n_fail++;
            $display("FAIL single_write_rsp got rv=%b err=%b rdata=%h owner=%0d exp rv=100 err=000 rdata=%h owner=2",
                     master_rvalid_o, master_err_o, master_rdata_o, owner_o, srdata);
        end
        advance();
        srvalid = 1'b0;
    endtask

    task automatic test_timeout();
        int seen = -1;
        req = 3'b001; sgnt = 1'b1; srvalid = 1'b0; random_fields();
        settle();
        advance();
        req = '0;
        for (int k = 1; k <= 20 && seen < 0; k++) begin
            settle();
            n_checks++;
            if (obs() !== exp_all) begin
                n_fail++; $display("FAIL timeout_wait cyc=%0d got=%h exp=%h", cyc, obs(), exp_all);
            end
            if (master_rvalid_o != '0) begin
                seen = k;
                n_checks++;
                if ({master_rvalid_o, master_err_o, master_rdata_o} !== {3'b001, 3'b001, 32'h0}) begin
                    n_fail++;
                    $display("FAIL timeout_err got rv=%b err=%b rdata=%h exp rv=001 err=001 rdata=0",
                             master_rvalid_o, master_err_o, master_rdata_o);
                end
            end
            advance();
        end
        n_checks++;
        if (seen != TIMEOUT) begin
            n_fail++; $display("FAIL timeout_latency got=%0d exp=%0d", seen, TIMEOUT);
        end
        srvalid = 1'b1; srdata = $urandom;
        settle();
        n_checks++;
        if ({master_rvalid_o, master_rdata_o} !== '0) begin
            n_fail++; $display("FAIL late_rvalid got rv=%b rdata=%h exp rv=000 rdata=0", master_rvalid_o, master_rdata_o);
        end
        advance();
        srvalid = 1'b0;
    endtask

    task automatic test_gnt_stall();
        sgnt = 1'b0; srvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req = (i >= 3) ? 3'b011 : 3'b010;
            random_fields();
            settle();
            n_checks++;
            if (master_gnt_o !== '0 || obs() !== exp_all) begin
                n_fail++; $display("FAIL gnt_stall cyc=%0d got=%h exp=%h", cyc, obs(), exp_all);
            end
            advance();
        end
        sgnt = 1'b1;
        settle();
        n_checks++;
        if (exp_win < 0 || master_gnt_o !== 3'(1 << exp_win) || obs() !== exp_all) begin
            n_fail++; $display("FAIL gnt_release cyc=%0d got gnt=%b exp winner=%0d", cyc, master_gnt_o, exp_win);
        end
        advance();
        drain();
    endtask

    task automatic test_reset_in_wait();
        req = '1; sgnt = 1'b1; srvalid = 1'b0; random_fields();
        settle();
        advance();
        rst = 1'b1;
        settle();
        n_checks++;
        if (obs() !== exp_all) begin
            n_fail++; $display("FAIL reset_in_wait cyc=%0d got=%h exp=%h", cyc, obs(), exp_all);
        end
        advance();
        settle();
        n_checks++;
        if (obs() !== '0) begin
            n_fail++; $display("FAIL reset_after_wait got=%h exp=0", obs());
        end
        advance();
        rst = 1'b0; srvalid = 1'b1;
        settle();
        n_checks++;
        if ({master_gnt_o, master_rvalid_o} !== {3'b001, 3'b000}) begin
            n_fail++; $display("FAIL post_reset_grant got gnt=%b rv=%b exp gnt=001 rv=000", master_gnt_o, master_rvalid_o);
        end
        srvalid = 1'b0;
        advance();
        drain();
    endtask

    task automatic test_rvalid_at_timeout();
        req = 3'b100; sgnt = 1'b1; srvalid = 1'b0; random_fields();
        settle();
        advance();
        req = '0;
        for (int k = 0; k < 40 && m_age < TIMEOUT; k++) begin
            settle();
            advance();
        end
        srvalid = 1'b1; srdata = $urandom;
        settle();
        n_checks++;
        if ({master_rvalid_o, master_err_o, master_rdata_o} !== {3'b100, 3'b000, srdata}) begin
            n_fail++;
            $display("FAIL rvalid_at_timeout got rv=%b err=%b rdata=%h exp rv=100 err=000 rdata=%h",
                     master_rvalid_o, master_err_o, master_rdata_o, srdata);
        end
        advance();
        srvalid = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(0, 59) == 0);
            req     = 3'($urandom);
            sgnt    = ($urandom_range(0, 3) != 0);
            srvalid = ($urandom_range(0, 4) == 0);
            random_fields();
            settle();
            n_checks++;
            if (obs() !== exp_all) begin
                n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs(), exp_all);
            end
            advance();
        end
        rst = 1'b0; srvalid = 1'b0;
        drain();
    endtask

    initial begin
        rst = 1'b1; req = '0; sgnt = 1'b0; srvalid = 1'b0;
        we = '0; be = '0; addr = '0; wdata = '0; srdata = '0;
        test_reset();
        test_rotation();
        test_single_write();
        test_timeout();
        test_gnt_stall();
        test_reset_in_wait();
        test_rvalid_at_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/obi_rr_arbiter.md
OBI_RR_ARBITER -- requirements
Module: obi_rr_arbiter

Interface
REQ-001 SHALL have parameter MASTERS, default 3, number of OBI requesters sharing one slave port.
REQ-002 SHALL have parameter TIMEOUT, default 16, number of cycles to wait for rvalid before an error response; legal range 2..255.
REQ-003 SHALL have ports, one per line, with clock and reset first:
- clk_i  input  1  single clock.
- rst_i  input  1  reset, synchronous, active-high.
- master_req_i  input  MASTERS  per-master request.
- master_gnt_o  output  MASTERS  per-master grant.
- master_rvalid_o  output  MASTERS  per-master response valid.
- master_err_o  output  MASTERS  per-master error, valid with rvalid.
- master_we_i  input  MASTERS  write enables.
- master_be_i  input  MASTERS*4  byte enables.
- master_addr_i  input  MASTERS*32  addresses.
- master_wdata_i  input  MASTERS*32  write data.
- master_rdata_o  output  32  read data, shared by all masters, qualified by master_rvalid_o.
- slave_req_o  output  1  request to the slave.
- slave_gnt_i  input  1  grant from the slave.
- slave_rvalid_i  input  1  response valid from the slave.
- slave_we_o  output  1  write enable to the slave.
- slave_be_o  output  4  byte enables to the slave.
- slave_addr_o  output  32  address to the slave.
- slave_wdata_o  output  32  write data to the slave.
- slave_rdata_i  input  32  read data from the slave.
- busy_o  output  1  high while a response is outstanding.
- owner_o  output  $clog2(MASTERS)  index of the current or last owner.

Function
REQ-004 SHALL implement two states: IDLE and WAIT_RSP.
REQ-005 SHALL, in IDLE, select the winner combinationally as the first asserted master_req_i, searching from rr_ptr upward modulo MASTERS.
REQ-006 SHALL, in IDLE with any request, assert slave_req_o and forward the winner's we/be/addr/wdata to the slave outputs in the same cycle.
REQ-007 SHALL otherwise drive slave_we_o=0, slave_be_o=0, slave_addr_o=0 and slave_wdata_o=0.
REQ-008 SHALL set master_gnt_o[winner]=slave_gnt_i combinationally in IDLE, and hold all other grant bits at 0.
REQ-009 SHALL, on a granted cycle (IDLE, request present, slave_gnt_i=1), register owner=winner, set rr_ptr=(winner+1) mod MASTERS, clear the timeout counter and move to WAIT_RSP.
REQ-010 SHALL re-evaluate the winner every IDLE cycle until a grant occurs; no lock is held before the grant.
REQ-011 SHALL, in WAIT_RSP, keep slave_req_o=0, all master_gnt_o bits at 0 and busy_o=1.
REQ-012 SHALL, in WAIT_RSP, increment the timeout counter by 1 per cycle; the counter is 8 bits and saturates.
REQ-013 SHALL, in WAIT_RSP with slave_rvalid_i=1, drive master_rvalid_o[owner]=1, master_err_o[owner]=0 and master_rdata_o=slave_rdata_i in the same cycle, then return to IDLE.
REQ-014 SHALL, in WAIT_RSP when the counter equals TIMEOUT-1 and slave_rvalid_i=0, drive master_rvalid_o[owner]=1, master_err_o[owner]=1 and master_rdata_o=0, then return to IDLE.
REQ-015 SHALL treat slave_rvalid_i and timeout in the same cycle as a normal response: err=0 and data forwarded.
REQ-016 SHALL ignore slave_rvalid_i in IDLE, including late responses after a timeout; no master_rvalid_o bit is asserted.
REQ-017 SHALL drive master_rdata_o=0 whenever no master_rvalid_o bit is asserted.
REQ-018 SHALL allow at most one outstanding transaction; a new grant is possible at the earliest in the cycle after the response.
REQ-019 SHALL drive owner_o from the owner register, holding its value in IDLE.
REQ-020 SHALL handle MASTERS=1 by keeping rr_ptr constant at 0.

Reset
REQ-021 SHALL, while rst_i=1 at a clk_i edge, set: state=IDLE, rr_ptr=0, owner=0, counter=0.
REQ-022 SHALL, during reset, drive all master_gnt_o, master_rvalid_o, master_err_o bits, slave_req_o and busy_o to 0.
REQ-023 SHALL let reset abort an outstanding transaction with no response to the owner; a slave rvalid after reset is ignored per REQ-016.

Verification
REQ-024 SHALL pass: masters 0,1,2 request continuously, slave gnt=1, rvalid one cycle after each grant -> grant order 0,1,2,0,1,2; each rvalid goes to the matching owner with that owner's rdata.
REQ-025 SHALL pass: only master 2 requests, addr=0x1000_0004, we=1, be=4'hF, wdata=0xA5A5_5A5A -> slave sees those values in the grant cycle; the response returns to master 2 with err=0.
REQ-026 SHALL pass: slave never asserts rvalid, TIMEOUT=16 -> master_rvalid_o[owner]=1 and err=1 with rdata=0 exactly 16 cycles after the grant; a late slave rvalid is ignored.
REQ-027 SHALL pass: slave_gnt_i low for 5 cycles while master 1 requests and master 0 starts requesting at cycle 3 -> no grant until gnt=1, then the winner follows rr_ptr order.
REQ-028 SHALL pass: rst_i asserted in WAIT_RSP -> the next cycle shows busy_o=0, owner_o=0 and all outputs 0; the first post-reset grant goes to master 0 when all request.
REQ-029 SHALL pass: rvalid arrives in the same cycle the counter reaches TIMEOUT-1 -> err=0 and rdata=slave_rdata_i.
